// File: rtl/sched_controller.sv
// ============================================================================
// Module      : sched_controller
// Description : Schedule-driven buffer toggle controller. A host loads a table
//               of schedule words while idle, then starts a run that replays
//               entries 0..period-1 in a loop, emitting per-buffer write/read
//               toggle strobes with an optional one-cycle stretch per buffer.
//
// Ports
//   clk, rst_n        : clock (rising edge), asynchronous active-low reset
//   ctrl_in           : schedule word, [NUM_BUFS-1:0] write toggles,
//                       [2*NUM_BUFS-1:NUM_BUFS] read toggles
//   load_ctrl         : write ctrl_in at wr_addr and advance (IDLE only)
//   load_clr          : return wr_addr to 0 (wins over load_ctrl)
//   period            : iteration length in entries, sampled at start
//   wr/rd_exp_mask    : live per-buffer stretch enables
//   start_ctrl        : start run / resume from DRAIN
//   stop_ctrl         : finish current iteration and stop
//   iter_limit        : (optional) iteration budget sampled at start, 0 = none
//   buff_wr/rd_toggle : per-buffer toggle strobes
//   busy              : high while RUN or DRAIN
//   iter_done         : pulse while the last entry of an iteration is shown
//   iter_count        : completed iterations since last start (wraps)
//   load_err, cfg_err : one-cycle error pulses
//
// Optional feature macro: SCHED_CTRL_ITER_LIMIT_EN adds the iter_limit input.
//
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sched_controller #(
  parameter int NUM_BUFS  = 12,
  parameter int MAX_DEPTH = 64,
  localparam int LSIZE    = $clog2(MAX_DEPTH),
  localparam int PSIZE    = $clog2(MAX_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [2*NUM_BUFS-1:0] ctrl_in,
  input  logic                  load_ctrl,
  input  logic                  load_clr,
  input  logic [PSIZE-1:0]      period,
  input  logic [NUM_BUFS-1:0]   wr_exp_mask,
  input  logic [NUM_BUFS-1:0]   rd_exp_mask,
  input  logic                  start_ctrl,
  input  logic                  stop_ctrl,
`ifdef SCHED_CTRL_ITER_LIMIT_EN
  input  logic [15:0]           iter_limit,
`endif
  output logic [NUM_BUFS-1:0]   buff_wr_toggle,
  output logic [NUM_BUFS-1:0]   buff_rd_toggle,
  output logic                  busy,
  output logic                  iter_done,
  output logic [15:0]           iter_count,
  output logic                  load_err,
  output logic                  cfg_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t                state;
  logic [2*NUM_BUFS-1:0] sched_mem [MAX_DEPTH];
  logic [LSIZE-1:0]      wr_addr;
  logic [LSIZE-1:0]      rd_addr;
  logic [PSIZE-1:0]      period_q;
  logic [2*NUM_BUFS-1:0] rd_data;
  logic [2*NUM_BUFS-1:0] rd_data_dly;

  logic mem_we;
  logic period_ok;
  logic last_entry;
  logic resume;
  logic limit_hit;

  assign mem_we     = (state == IDLE) && load_ctrl && !load_clr;
  assign period_ok  = (period != '0) && (period <= PSIZE'(MAX_DEPTH));
  assign last_entry = (PSIZE'(rd_addr) == (period_q - PSIZE'(1)));
  // start and stop together: stop wins
  assign resume     = start_ctrl && !stop_ctrl;

`ifdef SCHED_CTRL_ITER_LIMIT_EN
  logic [15:0] limit_q;
  // Enter DRAIN early enough that the final iteration is the limit-th one.
  assign limit_hit = (state == RUN) && (limit_q != 16'd0) &&
                     (iter_count == (limit_q - 16'd1));
`else
  assign limit_hit = 1'b0;
`endif

  // Schedule storage deliberately has no reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      sched_mem[wr_addr] <= ctrl_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      wr_addr     <= '0;
      rd_addr     <= '0;
      period_q    <= '0;
      rd_data     <= '0;
      rd_data_dly <= '0;
      iter_count  <= '0;
      iter_done   <= 1'b0;
      busy        <= 1'b0;
      load_err    <= 1'b0;
      cfg_err     <= 1'b0;
`ifdef SCHED_CTRL_ITER_LIMIT_EN
      limit_q     <= '0;
`endif
    end else begin
      rd_data_dly <= rd_data;
      iter_done   <= 1'b0;
      load_err    <= 1'b0;
      cfg_err     <= 1'b0;
      case (state)
        IDLE: begin
          // Zero read data so raw toggles stop; only the stretch tail remains.
          rd_data <= '0;
          rd_addr <= '0;
          if (load_clr) begin
            wr_addr <= '0;
          end else if (load_ctrl) begin
            wr_addr <= (wr_addr == LSIZE'(MAX_DEPTH - 1)) ? '0 : wr_addr + LSIZE'(1);
          end
          if (resume) begin
            if (period_ok) begin
              state      <= RUN;
              busy       <= 1'b1;
              period_q   <= period;
              iter_count <= '0;
`ifdef SCHED_CTRL_ITER_LIMIT_EN
              limit_q    <= iter_limit;
`endif
            end else begin
              cfg_err <= 1'b1;
            end
          end
        end
        default: begin
          // RUN or DRAIN: loads are refused and flagged.
          load_err <= load_ctrl;
          if ((state == DRAIN) && iter_done && !resume) begin
            // The final iteration has just been shown; wind down.
            state   <= IDLE;
            busy    <= 1'b0;
            rd_data <= '0;
            rd_addr <= '0;
          end else begin
            rd_data <= sched_mem[rd_addr];
            rd_addr <= last_entry ? '0 : rd_addr + LSIZE'(1);
            if (last_entry) begin
              iter_done  <= 1'b1;
              iter_count <= iter_count + 16'd1;
            end
            if (stop_ctrl || limit_hit) begin
              state <= DRAIN;
            end else if (start_ctrl) begin
              state <= RUN;
            end
          end
        end
      endcase
    end
  end

  assign buff_wr_toggle = rd_data[NUM_BUFS-1:0] |
                          (wr_exp_mask & rd_data_dly[NUM_BUFS-1:0]);
  assign buff_rd_toggle = rd_data[2*NUM_BUFS-1:NUM_BUFS] |
                          (rd_exp_mask & rd_data_dly[2*NUM_BUFS-1:NUM_BUFS]);

endmodule

`default_nettype wire

// File: tb/tb_sched_controller.sv
// ============================================================================
// Module      : tb_sched_controller
// Description : Self-checking bench for sched_controller: directed table,
//               hand-written corner sequences and randomized traffic checked
//               against an entry-level behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sched_controller;

  localparam int NB    = 4;
  localparam int DEPTH = 8;
  localparam int PW    = $clog2(DEPTH + 1);

  logic            clk = 1'b0;
  logic            rst_n;
  logic [2*NB-1:0] ctrl_in;
  logic            load_ctrl, load_clr, start_ctrl, stop_ctrl;
  logic [PW-1:0]   period;
  logic [NB-1:0]   wr_exp_mask, rd_exp_mask;
  logic [15:0]     iter_limit;
  logic [NB-1:0]   buff_wr_toggle, buff_rd_toggle;
  logic            busy, iter_done, load_err, cfg_err;
  logic [15:0]     iter_count;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  sched_controller #(.NUM_BUFS(NB), .MAX_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .ctrl_in(ctrl_in), .load_ctrl(load_ctrl),
    .load_clr(load_clr), .period(period), .wr_exp_mask(wr_exp_mask),
    .rd_exp_mask(rd_exp_mask), .start_ctrl(start_ctrl), .stop_ctrl(stop_ctrl),
`ifdef SCHED_CTRL_ITER_LIMIT_EN
    .iter_limit(iter_limit),
`endif
    .buff_wr_toggle(buff_wr_toggle), .buff_rd_toggle(buff_rd_toggle),
    .busy(busy), .iter_done(iter_done), .iter_count(iter_count),
    .load_err(load_err), .cfg_err(cfg_err)
  );

  // ---------------- behavioural model ----------------
  // mode: 0 idle, 1 running, 2 finishing. vis = entry index currently shown.
  logic [2*NB-1:0] m_mem [DEPTH];
  int              m_mode, m_wa, m_per, m_vis, m_cnt, m_lim;
  logic            m_done, m_lerr, m_cerr, m_go, m_lim_hit;
  logic [2*NB-1:0] m_raw, m_prev;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = 0; m_wa = 0; m_per = 0; m_vis = -1; m_cnt = 0; m_lim = 0;
      m_done = 0; m_lerr = 0; m_cerr = 0; m_raw = '0; m_prev = '0;
    end else begin
      m_go   = start_ctrl && !stop_ctrl;
      m_prev = m_raw;
      m_lerr = 0;
      m_cerr = 0;
      if (m_mode == 0) begin
        m_raw  = '0;
        m_done = 0;
        if (load_clr) m_wa = 0;
        else if (load_ctrl) begin
          m_mem[m_wa] = ctrl_in;
          m_wa = (m_wa + 1) % DEPTH;
        end
        if (m_go) begin
          if (period >= 1 && period <= DEPTH) begin
            m_mode = 1; m_per = int'(period); m_cnt = 0; m_vis = -1;
`ifdef SCHED_CTRL_ITER_LIMIT_EN
            m_lim = int'(iter_limit);
`else
            m_lim = 0;
`endif
          end else m_cerr = 1;
        end
      end else begin
        m_lerr = load_ctrl;
        if (m_mode == 2 && m_done && !m_go) begin
          m_mode = 0; m_raw = '0; m_done = 0; m_vis = -1;
        end else begin
          m_lim_hit = (m_mode == 1) && (m_lim != 0) && (m_cnt == m_lim - 1);
          m_vis  = (m_vis + 1) % m_per;
          m_raw  = m_mem[m_vis];
          m_done = (m_vis == m_per - 1);
          if (m_done) m_cnt = (m_cnt + 1) % 65536;
          if (stop_ctrl || m_lim_hit) m_mode = 2;
          else if (start_ctrl) m_mode = 1;
        end
      end
    end
  end

  // ---------------- checking helpers ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  task automatic check_model();
    logic [NB-1:0] ew, er;
    ew = m_raw[NB-1:0] | (wr_exp_mask & m_prev[NB-1:0]);
    er = m_raw[2*NB-1:NB] | (rd_exp_mask & m_prev[2*NB-1:NB]);
    chk("m_wr_toggle", 32'(buff_wr_toggle), 32'(ew));
    chk("m_rd_toggle", 32'(buff_rd_toggle), 32'(er));
    chk("m_busy",      32'(busy),       32'(m_mode != 0));
    chk("m_iter_done", 32'(iter_done),  32'(m_done));
    chk("m_iter_count",32'(iter_count), 32'(m_cnt));
    chk("m_load_err",  32'(load_err),   32'(m_lerr));
    chk("m_cfg_err",   32'(cfg_err),    32'(m_cerr));
  endtask

  task automatic tick();
    @(negedge clk);
    check_model();
  endtask

  task automatic pulses_off();
    load_ctrl = 0; load_clr = 0; start_ctrl = 0; stop_ctrl = 0;
  endtask

  task automatic wait_idle();
    stop_ctrl = 1; tick(); stop_ctrl = 0;
    for (int i = 0; i < 20 && busy; i++) tick();
    chk("idle_timeout", 32'(busy), 32'd0);
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic          start, stop;
    logic [NB-1:0] wmask, ewr, erd;
    logic          edone, ebusy;
    logic [15:0]   ecnt;
  } vec_t;

  vec_t vt [10];
  logic [2*NB-1:0] words [DEPTH];
  int done_pulses;

  initial begin
    // Entry 0 toggles write buffer 0, entry 2 toggles read buffer 3.
    vt[0] = '{1, 0, 4'h1, 4'h0, 4'h0, 0, 1, 16'd0};
    vt[1] = '{0, 0, 4'h1, 4'h1, 4'h0, 0, 1, 16'd0};
    vt[2] = '{0, 0, 4'h1, 4'h1, 4'h0, 0, 1, 16'd0};  // stretched tail
    vt[3] = '{0, 0, 4'h1, 4'h0, 4'h8, 0, 1, 16'd0};
    vt[4] = '{0, 0, 4'h0, 4'h0, 4'h0, 1, 1, 16'd1};
    vt[5] = '{0, 0, 4'h0, 4'h1, 4'h0, 0, 1, 16'd1};
    vt[6] = '{0, 0, 4'h0, 4'h0, 4'h0, 0, 1, 16'd1};  // no stretch with mask 0
    vt[7] = '{0, 1, 4'h0, 4'h0, 4'h8, 0, 1, 16'd1};  // stop mid iteration 2
    vt[8] = '{0, 0, 4'h0, 4'h0, 4'h0, 1, 1, 16'd2};
    vt[9] = '{0, 0, 4'h0, 4'h0, 4'h0, 0, 0, 16'd2};

    rst_n = 0; pulses_off(); ctrl_in = '0; period = '0;
    wr_exp_mask = '0; rd_exp_mask = '0; iter_limit = '0;
    tick(); tick();
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_count", 32'(iter_count), 32'd0);
    rst_n = 1;
    tick();

    // Load the whole table.
    words[0] = 8'h01; words[1] = 8'h00; words[2] = 8'h80; words[3] = 8'h00;
    for (int i = 4; i < DEPTH; i++) words[i] = 8'($urandom);
    load_clr = 1; tick(); load_clr = 0;
    for (int i = 0; i < DEPTH; i++) begin
      load_ctrl = 1; ctrl_in = words[i]; tick();
    end
    load_ctrl = 0;

    // Table run, period 4.
    period = 4;
    for (int j = 0; j < 10; j++) begin
      start_ctrl = vt[j].start; stop_ctrl = vt[j].stop; wr_exp_mask = vt[j].wmask;
      tick();
      chk($sformatf("tbl%0d_wr", j),   32'(buff_wr_toggle), 32'(vt[j].ewr));
      chk($sformatf("tbl%0d_rd", j),   32'(buff_rd_toggle), 32'(vt[j].erd));
      chk($sformatf("tbl%0d_done", j), 32'(iter_done),      32'(vt[j].edone));
      chk($sformatf("tbl%0d_busy", j), 32'(busy),           32'(vt[j].ebusy));
      chk($sformatf("tbl%0d_cnt", j),  32'(iter_count),     32'(vt[j].ecnt));
    end
    pulses_off(); wr_exp_mask = '0;

    // Illegal periods.
    period = 0; start_ctrl = 1; tick(); start_ctrl = 0;
    chk("cfg_err_p0", 32'(cfg_err), 32'd1);
    chk("cfg_busy_p0", 32'(busy), 32'd0);
    tick();
    chk("cfg_err_clear", 32'(cfg_err), 32'd0);
    period = PW'(DEPTH + 1); start_ctrl = 1; tick(); start_ctrl = 0;
    chk("cfg_err_pmax", 32'(cfg_err), 32'd1);
    chk("cfg_busy_pmax", 32'(busy), 32'd0);
    tick();

    // Start and stop together in idle: nothing happens.
    period = 4; start_ctrl = 1; stop_ctrl = 1; tick(); pulses_off();
    chk("startstop_idle_busy", 32'(busy), 32'd0);
    chk("startstop_idle_cfg", 32'(cfg_err), 32'd0);

    // Period = MAX_DEPTH is legal.
    period = PW'(DEPTH); start_ctrl = 1; tick(); start_ctrl = 0;
    chk("pmax_legal_busy", 32'(busy), 32'd1);
    for (int i = 0; i < DEPTH + 2; i++) tick();
    wait_idle();

    // Load while running is refused.
    period = 4; start_ctrl = 1; tick(); start_ctrl = 0;
    tick();
    load_ctrl = 1; ctrl_in = 8'hFF; tick(); load_ctrl = 0;
    chk("load_err_pulse", 32'(load_err), 32'd1);
    for (int i = 0; i < 6; i++) tick();
    wait_idle();

    // Asynchronous reset mid-run, then replay from entry 0.
    period = 3; start_ctrl = 1; tick(); start_ctrl = 0;
    tick(); tick();
    wr_exp_mask = 4'hF; rd_exp_mask = 4'hF;
    #2 rst_n = 0;
    #1;
    chk("arst_wr", 32'(buff_wr_toggle), 32'd0);
    chk("arst_rd", 32'(buff_rd_toggle), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_cnt", 32'(iter_count), 32'd0);
    tick();
    rst_n = 1; wr_exp_mask = '0; rd_exp_mask = '0;
    tick(); tick();
    chk("post_rst_idle", 32'(busy), 32'd0);
    period = 4; start_ctrl = 1; tick(); start_ctrl = 0;
    tick();
    chk("replay_entry0", 32'(buff_wr_toggle), 32'h1);
    wait_idle();

    // Randomized traffic against the model.
    for (int c = 0; c < 600; c++) begin
      start_ctrl  = ($urandom % 8) == 0;
      stop_ctrl   = ($urandom % 12) == 0;
      load_ctrl   = ($urandom % 10) == 0;
      load_clr    = ($urandom % 40) == 0;
      ctrl_in     = 8'($urandom);
      period      = PW'($urandom_range(0, DEPTH + 1));
      wr_exp_mask = NB'($urandom);
      rd_exp_mask = NB'($urandom);
      iter_limit  = 16'($urandom_range(0, 3));
      tick();
    end
    pulses_off();
    wait_idle();

`ifdef SCHED_CTRL_ITER_LIMIT_EN
    // Iteration budget: exactly three iterations, then idle.
    iter_limit = 3; period = 5; start_ctrl = 1; tick(); start_ctrl = 0;
    done_pulses = 0;
    for (int i = 0; i < 40 && busy; i++) begin
      tick();
      if (iter_done) done_pulses++;
    end
    chk("limit_done_pulses", 32'(done_pulses), 32'd3);
    chk("limit_idle", 32'(busy), 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
